// File: rtl/axi4_switch_pkg.sv
// Shared helpers, beat type and illegal-use assertion macro for the AXI4 switch W-path stages.
`ifndef AXI4_SWITCH_PKG_SV
`define AXI4_SWITCH_PKG_SV

`define SW_ASSERT_NEVER(label, clk, rst, cond) \
    label: assert property (@(posedge clk) disable iff (rst) !(cond)) \
        else $error("axi4_switch: %m violated");

package axi4_switch_pkg;

    localparam int unsigned W_DW = 64;

    // Index width for a port count; a single port still needs one select bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic [W_DW-1:0]   data;
        logic [W_DW/8-1:0] strb;
        logic              last;
    } w_beat_t;

endpackage

`endif

// File: rtl/order_fifo.sv
// Small ordering FIFO holding routing indices in AW-accepted order.
module order_fifo
    import axi4_switch_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned FD    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned PW = $clog2(FD);
    localparam int unsigned CW = $clog2(FD) + 1;

    logic [WIDTH-1:0] mem_q [FD];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(FD));
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every next-state value gets a default first so no path infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; the reset counter marks it empty, so stale entries are never used.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    `SW_ASSERT_NEVER(a_no_overflow, clk, rst, push_i && full_o)
    `SW_ASSERT_NEVER(a_no_underflow, clk, rst, pop_i && empty_o)

endmodule

// File: rtl/axi4_wdata_router.sv
// W-channel router: steers master W bursts to slaves in the order their AWs were accepted.
module axi4_wdata_router
    import axi4_switch_pkg::*;
#(
    parameter int unsigned M     = 2,
    parameter int unsigned N     = 2,
    parameter int unsigned DW    = 64,
    parameter int unsigned FD    = 4,
    parameter int unsigned LOG_M = clog2_min1(M),
    parameter int unsigned LOG_N = clog2_min1(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     aw_fire_i,
    input  logic [LOG_M-1:0] aw_src_i     [N],
    output logic [N-1:0]     aw_room_o,
    input  logic [M-1:0]     m_axi_wvalid,
    input  logic [DW-1:0]    m_axi_wdata  [M],
    input  logic [DW/8-1:0]  m_axi_wstrb  [M],
    input  logic [M-1:0]     m_axi_wlast,
    output logic [M-1:0]     m_axi_wready,
    output logic [N-1:0]     s_axi_wvalid,
    output logic [DW-1:0]    s_axi_wdata  [N],
    output logic [DW/8-1:0]  s_axi_wstrb  [N],
    output logic [N-1:0]     s_axi_wlast,
    input  logic [N-1:0]     s_axi_wready
);

    logic [M-1:0]     m_push, m_pop, m_empty, m_full, m_match;
    logic [LOG_N-1:0] m_push_tgt [M];
    logic [LOG_N-1:0] m_head     [M];

    logic [N-1:0]     s_pop, s_empty, s_full, s_match;
    logic [LOG_M-1:0] s_head [N];

    logic             aw_dup_src;

    for (genvar gi = 0; gi < M; gi++) begin : g_mfifo
        order_fifo #(.WIDTH(LOG_N), .FD(FD)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (m_push[gi]),
            .data_i  (m_push_tgt[gi]),
            .pop_i   (m_pop[gi]),
            .head_o  (m_head[gi]),
            .empty_o (m_empty[gi]),
            .full_o  (m_full[gi])
        );
    end

    for (genvar gj = 0; gj < N; gj++) begin : g_sfifo
        order_fifo #(.WIDTH(LOG_M), .FD(FD)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (aw_fire_i[gj]),
            .data_i  (aw_src_i[gj]),
            .pop_i   (s_pop[gj]),
            .head_o  (s_head[gj]),
            .empty_o (s_empty[gj]),
            .full_o  (s_full[gj])
        );
    end

    // Conservative admission: a pop in the same cycle does not free room early.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            aw_room_o[j] = !s_full[j] && !m_full[aw_src_i[j]];
        end
    end

    // Master side: record each granted target and grant wready when both FIFO heads agree.
    always_comb begin
        m_push = '0;
        for (int i = 0; i < M; i++) begin
            m_push_tgt[i]   = '0;
            m_match[i]      = !m_empty[i] && !s_empty[m_head[i]] &&
                              (s_head[m_head[i]] == LOG_M'(i));
            m_axi_wready[i] = m_match[i] && s_axi_wready[m_head[i]];
            m_pop[i]        = m_axi_wready[i] && m_axi_wvalid[i] && m_axi_wlast[i];
        end
        for (int j = 0; j < N; j++) begin
            if (aw_fire_i[j]) begin
                m_push[aw_src_i[j]]     = 1'b1;
                m_push_tgt[aw_src_i[j]] = LOG_N'(j);
            end
        end
    end

    // Slave side: zero-latency mux from the matched master; idle slaves drive zeros.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            s_match[j] = !s_empty[j] && !m_empty[s_head[j]] &&
                         (m_head[s_head[j]] == LOG_N'(j));
            if (s_match[j]) begin
                s_axi_wvalid[j] = m_axi_wvalid[s_head[j]];
                s_axi_wdata[j]  = m_axi_wdata[s_head[j]];
                s_axi_wstrb[j]  = m_axi_wstrb[s_head[j]];
                s_axi_wlast[j]  = m_axi_wlast[s_head[j]];
            end else begin
                s_axi_wvalid[j] = 1'b0;
                s_axi_wdata[j]  = '0;
                s_axi_wstrb[j]  = '0;
                s_axi_wlast[j]  = 1'b0;
            end
            s_pop[j] = s_axi_wvalid[j] && s_axi_wready[j] && s_axi_wlast[j];
        end
    end

    always_comb begin
        aw_dup_src = 1'b0;
        for (int a = 0; a < N; a++) begin
            for (int b = a + 1; b < N; b++) begin
                if (aw_fire_i[a] && aw_fire_i[b] && (aw_src_i[a] == aw_src_i[b])) aw_dup_src = 1'b1;
            end
        end
    end

    `SW_ASSERT_NEVER(a_aw_dup_src, clk, rst, aw_dup_src)
    `SW_ASSERT_NEVER(a_aw_no_room, clk, rst, |(aw_fire_i & ~aw_room_o))

endmodule
